rf_writeback: RTL

// - Write-side driver for the 32x32 register file: receives retiring results from MEM,

---
 rtl/rf_writeback.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/rf_writeback.sv
// rf_writeback: write-side driver for the 32x32 register file.
//
// Retiring MEM results are held in a 2-entry in-order skid buffer. The head entry drives the
// register file write port. A per-register pending-write scoreboard lets decode detect RAW
// hazards against its register file reads.
//
// Optional feature macro: RF_BYPASS_FWD_EN
//   When defined, the commit value is forwarded to decode (fwd_* ports). A reader whose last
//   pending write is committing this cycle is then not stalled.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   mem_valid / mem_ready       MEM result handshake (ready = buffer not full)
//   mem_rd, mem_regwrite        destination register and write enable of the MEM result
//   mem_memtoreg                selects mem_load_data (1) or mem_alu_result (0)
//   mem_alu_result, mem_load_data  candidate result values
//   wb_stall                    hold commit this cycle
//   iss_valid / iss_ready       decode issue handshake (ready = destination counter not saturated)
//   iss_rd, iss_regwrite        issued destination and its write enable
//   read_reg_1/2, hazard_1/2    decode sources and their pending-write flags
//   write_reg, write_data, regWrite  register file write port
//   fwd_data_1/2, fwd_hit_1/2   commit-cycle bypass (RF_BYPASS_FWD_EN only)

module rf_writeback #(
    parameter int unsigned CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    input  logic        mem_memtoreg,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_load_data,
    input  logic        wb_stall,
    input  logic        iss_valid,
    output logic        iss_ready,
    input  logic [4:0]  iss_rd,
    input  logic        iss_regwrite,
    input  logic [4:0]  read_reg_1,
    input  logic [4:0]  read_reg_2,
    output logic        hazard_1,
    output logic        hazard_2,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        regWrite
`ifdef RF_BYPASS_FWD_EN
    ,
    output logic [31:0] fwd_data_1,
    output logic [31:0] fwd_data_2,
    output logic        fwd_hit_1,
    output logic        fwd_hit_2
`endif
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } buf_state_e;

    buf_state_e r_state;

    // Entry 0 is always the head; entry 1 only holds data in StTwo.
    logic [4:0]  r_head_rd;
    logic        r_head_rw;
    logic [31:0] r_head_data;
    logic [4:0]  r_tail_rd;
    logic        r_tail_rw;
    logic [31:0] r_tail_data;

    logic [CNT_W-1:0] r_cnt [32];

    logic        w_head_valid;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_push_data;
    logic        w_iss_fire;
    logic [CNT_W-1:0] w_cnt_1;
    logic [CNT_W-1:0] w_cnt_2;

    // ------------------------------------------------------------------
    // Skid buffer and commit
    // ------------------------------------------------------------------
    assign w_head_valid = (r_state != StEmpty);
    assign mem_ready    = (r_state != StTwo);
    assign w_push       = mem_valid && mem_ready;
    assign w_push_data  = mem_memtoreg ? mem_load_data : mem_alu_result;

    // A commit pops the head even when it does not write (regwrite=0 or rd=0).
    // Gating with rst drops the write in the very cycle reset is asserted.
    assign w_pop      = w_head_valid && !wb_stall && !rst;
    assign regWrite   = w_pop && r_head_rw && (r_head_rd != 5'd0);
    assign write_reg  = w_head_valid ? r_head_rd : 5'd0;
    assign write_data = w_head_valid ? r_head_data : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StEmpty;
            r_head_rd   <= 5'd0;
            r_head_rw   <= 1'b0;
            r_head_data <= 32'd0;
            r_tail_rd   <= 5'd0;
            r_tail_rw   <= 1'b0;
            r_tail_data <= 32'd0;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_push) begin
                        r_head_rd   <= mem_rd;
                        r_head_rw   <= mem_regwrite;
                        r_head_data <= w_push_data;
                        r_state     <= StOne;
                    end
                end
                StOne: begin
                    if (w_push && w_pop) begin
                        r_head_rd   <= mem_rd;
                        r_head_rw   <= mem_regwrite;
                        r_head_data <= w_push_data;
                    end else if (w_push) begin
                        r_tail_rd   <= mem_rd;
                        r_tail_rw   <= mem_regwrite;
                        r_tail_data <= w_push_data;
                        r_state     <= StTwo;
                    end else if (w_pop) begin
                        r_state <= StEmpty;
                    end
                end
                StTwo: begin
                    // No push can arrive here: mem_ready is low while full.
                    if (w_pop) begin
                        r_head_rd   <= r_tail_rd;
                        r_head_rw   <= r_tail_rw;
                        r_head_data <= r_tail_data;
                        r_state     <= StOne;
                    end
                end
                default: r_state <= StEmpty;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
    assign iss_ready  = !(iss_regwrite && (r_cnt[iss_rd] == CntMax));
    assign w_iss_fire = iss_valid && iss_ready && iss_regwrite && (iss_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            r_cnt[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                // A commit to a register with no pending write is ignored (no underflow).
                if ((w_iss_fire && (iss_rd == 5'(r))) &&
                    !(regWrite && (write_reg == 5'(r)) && (r_cnt[r] != '0))) begin
                    r_cnt[r] <= r_cnt[r] + CntOne;
                end else if (!(w_iss_fire && (iss_rd == 5'(r))) &&
                             (regWrite && (write_reg == 5'(r)) && (r_cnt[r] != '0))) begin
                    r_cnt[r] <= r_cnt[r] - CntOne;
                end
            end
        end
    end

    assign w_cnt_1 = r_cnt[read_reg_1];
    assign w_cnt_2 = r_cnt[read_reg_2];

`ifdef RF_BYPASS_FWD_EN
    assign fwd_hit_1  = regWrite && (write_reg == read_reg_1) && (read_reg_1 != 5'd0);
    assign fwd_hit_2  = regWrite && (write_reg == read_reg_2) && (read_reg_2 != 5'd0);
    assign fwd_data_1 = write_data;
    assign fwd_data_2 = write_data;

    // The last outstanding write committing now is served by the bypass instead of a stall.
    assign hazard_1 = (read_reg_1 != 5'd0) && (w_cnt_1 != '0) &&
                      !(fwd_hit_1 && (w_cnt_1 == CntOne));
    assign hazard_2 = (read_reg_2 != 5'd0) && (w_cnt_2 != '0) &&
                      !(fwd_hit_2 && (w_cnt_2 == CntOne));
`else
    assign hazard_1 = (read_reg_1 != 5'd0) && (w_cnt_1 != '0);
    assign hazard_2 = (read_reg_2 != 5'd0) && (w_cnt_2 != '0);
`endif

endmodule
